// File: rtl/ordena_8_num_seq.sv
// ordena_8_num_seq: registered eight-way unsigned sorter.
// Eight 8-bit operands are sorted by a Batcher odd-even merge network
// (19 compare-exchange cells, 6 layers). The network always sorts ascending;
// descending order is obtained by reversing the result before the output
// register. Build option: define ORDENA_PIPE_EN to insert a pipeline register
// after layer 3 (latency 2 instead of 1, throughput unchanged).
module ordena_8_num_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       cresc_ou_decres,
    input  logic [7:0] n1_n,
    input  logic [7:0] n2_n,
    input  logic [7:0] n3_n,
    input  logic [7:0] n4_n,
    input  logic [7:0] n5_n,
    input  logic [7:0] n6_n,
    input  logic [7:0] n7_n,
    input  logic [7:0] n8_n,
    output logic [7:0] n1,
    output logic [7:0] n2,
    output logic [7:0] n3,
    output logic [7:0] n4,
    output logic [7:0] n5,
    output logic [7:0] n6,
    output logic [7:0] n7,
    output logic [7:0] n8,
    output logic       valid
);

    // Element i of a packed vector lives at bits [8*i +: 8]; element 0 maps to n1.
    logic [63:0] w_in;
    logic [63:0] w_sorted;
    logic        w_dir;
    logic        w_load;
    logic [63:0] r_out;
    logic        r_valid;

    assign w_in = {n8_n, n7_n, n6_n, n5_n, n4_n, n3_n, n2_n, n1_n};

    // Compare-exchange cell: returns {max, min}.
    function automatic logic [15:0] f_cx(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? {a, b} : {b, a};
    endfunction

    // Layers 1..3: sort pairs, then merge pairs into sorted groups of four.
    function automatic logic [63:0] f_layers_1_3(input logic [63:0] i_vec);
        logic [7:0]  v [8];
        logic [63:0] o_vec;
        for (int i = 0; i < 8; i++) v[i] = i_vec[8*i +: 8];
        {v[1], v[0]} = f_cx(v[0], v[1]);
        {v[3], v[2]} = f_cx(v[2], v[3]);
        {v[5], v[4]} = f_cx(v[4], v[5]);
        {v[7], v[6]} = f_cx(v[6], v[7]);
        {v[2], v[0]} = f_cx(v[0], v[2]);
        {v[3], v[1]} = f_cx(v[1], v[3]);
        {v[6], v[4]} = f_cx(v[4], v[6]);
        {v[7], v[5]} = f_cx(v[5], v[7]);
        {v[2], v[1]} = f_cx(v[1], v[2]);
        {v[6], v[5]} = f_cx(v[5], v[6]);
        o_vec = '0;
        for (int i = 0; i < 8; i++) o_vec[8*i +: 8] = v[i];
        return o_vec;
    endfunction

    // Layers 4..6: merge the two sorted groups of four into eight.
    function automatic logic [63:0] f_layers_4_6(input logic [63:0] i_vec);
        logic [7:0]  v [8];
        logic [63:0] o_vec;
        for (int i = 0; i < 8; i++) v[i] = i_vec[8*i +: 8];
        {v[4], v[0]} = f_cx(v[0], v[4]);
        {v[5], v[1]} = f_cx(v[1], v[5]);
        {v[6], v[2]} = f_cx(v[2], v[6]);
        {v[7], v[3]} = f_cx(v[3], v[7]);
        {v[4], v[2]} = f_cx(v[2], v[4]);
        {v[5], v[3]} = f_cx(v[3], v[5]);
        {v[2], v[1]} = f_cx(v[1], v[2]);
        {v[4], v[3]} = f_cx(v[3], v[4]);
        {v[6], v[5]} = f_cx(v[5], v[6]);
        o_vec = '0;
        for (int i = 0; i < 8; i++) o_vec[8*i +: 8] = v[i];
        return o_vec;
    endfunction

    // Swap element order end-for-end (ascending -> descending).
    function automatic logic [63:0] f_reverse(input logic [63:0] i_vec);
        logic [63:0] o_vec;
        o_vec = '0;
        for (int i = 0; i < 8; i++) o_vec[8*i +: 8] = i_vec[8*(7-i) +: 8];
        return o_vec;
    endfunction

`ifdef ORDENA_PIPE_EN
    logic [63:0] r_mid;
    logic        r_mid_dir;
    logic        r_mid_vld;

    // Mid-network stage: holds layer-3 results with their direction; stalls with ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mid     <= '0;
            r_mid_dir <= 1'b0;
            r_mid_vld <= 1'b0;
        end else if (ena) begin
            r_mid     <= f_layers_1_3(w_in);
            r_mid_dir <= cresc_ou_decres;
            r_mid_vld <= 1'b1;
        end
    end

    assign w_sorted = f_layers_4_6(r_mid);
    assign w_dir    = r_mid_dir;
    // Output only advances once a real sample has reached the middle stage.
    assign w_load   = ena & r_mid_vld;
`else
    assign w_sorted = f_layers_4_6(f_layers_1_3(w_in));
    assign w_dir    = cresc_ou_decres;
    assign w_load   = ena;
`endif

    // Output register: loads the (optionally reversed) sort; valid sticks until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_out   <= w_dir ? f_reverse(w_sorted) : w_sorted;
            r_valid <= 1'b1;
        end
    end

    assign n1    = r_out[7:0];
    assign n2    = r_out[15:8];
    assign n3    = r_out[23:16];
    assign n4    = r_out[31:24];
    assign n5    = r_out[39:32];
    assign n6    = r_out[47:40];
    assign n7    = r_out[55:48];
    assign n8    = r_out[63:56];
    assign valid = r_valid;

endmodule

// File: tb/tb_ordena_8_num_seq.sv
// Scoreboard bench for ordena_8_num_seq: the driver pushes the reference
// sort of every accepted sample; the monitor retires entries as the DUT
// advances and compares outputs and valid after every clock edge.
module tb_ordena_8_num_seq;

`ifdef ORDENA_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] n_in  [8];
    logic [7:0] n_out [8];
    logic       valid;

    logic [63:0] sb [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ordena_8_num_seq dut (
        .clk(clk), .rst(rst), .ena(ena), .cresc_ou_decres(dir),
        .n1_n(n_in[0]), .n2_n(n_in[1]), .n3_n(n_in[2]), .n4_n(n_in[3]),
        .n5_n(n_in[4]), .n6_n(n_in[5]), .n7_n(n_in[6]), .n8_n(n_in[7]),
        .n1(n_out[0]), .n2(n_out[1]), .n3(n_out[2]), .n4(n_out[3]),
        .n5(n_out[4]), .n6(n_out[5]), .n7(n_out[6]), .n8(n_out[7]),
        .valid(valid)
    );

    // Reference: plain queue sort of the multiset, reversed for descending.
    function automatic logic [63:0] ref_sort(input logic [63:0] v, input logic d);
        logic [7:0]  q [$];
        logic [63:0] r;
        for (int i = 0; i < 8; i++) q.push_back(v[8*i +: 8]);
        q.sort();
        if (d) q.reverse();
        r = '0;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = q[i];
        return r;
    endfunction

    function automatic logic [63:0] pk(input int a1, a2, a3, a4, a5, a6, a7, a8);
        return {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0]};
    endfunction

    function automatic logic [63:0] rnd_vec();
        return {$urandom(), $urandom()};
    endfunction

    task automatic step(input logic r, input logic e, input logic d, input logic [63:0] v);
        @(negedge clk);
        rst = r;
        ena = e;
        dir = d;
        for (int i = 0; i < 8; i++) n_in[i] = v[8*i +: 8];
        if (e && !r) sb.push_back(ref_sort(v, d));
    endtask

    // Monitor: tracks the expected output state and compares after each edge.
    initial begin : monitor
        logic        s_rst, s_ena, started;
        logic [63:0] exp_out, got;
        logic        exp_valid;
        started   = 1'b0;
        exp_out   = '0;
        exp_valid = 1'b0;
        forever begin
            @(posedge clk);
            s_rst = rst;
            s_ena = ena;
            #1;
            if (s_rst) begin
                sb.delete();
                exp_out   = '0;
                exp_valid = 1'b0;
                started   = 1'b1;
            end else if (s_ena && sb.size() >= LAT) begin
                exp_out   = sb.pop_front();
                exp_valid = 1'b1;
            end
            if (started) begin
                got = {n_out[7], n_out[6], n_out[5], n_out[4],
                       n_out[3], n_out[2], n_out[1], n_out[0]};
                total++;
                if (got !== exp_out) begin
                    bad++;
                    $display("FAIL data @%0t: got %h want %h", $time, got, exp_out);
                end
                total++;
                if (valid !== exp_valid) begin
                    bad++;
                    $display("FAIL valid @%0t: got %b want %b", $time, valid, exp_valid);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) n_in[i] = 8'h00;
        // Reset with arbitrary inputs, then idle with ena low.
        step(1, 1, 1, rnd_vec());
        step(1, 0, 0, rnd_vec());
        for (int i = 0; i < 3; i++) step(0, 0, i[0], rnd_vec());
        // Directed patterns.
        step(0, 1, 0, pk(1, 2, 3, 4, 5, 6, 7, 8));
        step(0, 1, 0, pk(8, 7, 6, 5, 4, 3, 2, 1));
        step(0, 1, 1, pk(8, 7, 6, 5, 4, 3, 2, 1));
        step(0, 1, 1, pk(1, 2, 3, 4, 5, 6, 7, 8));
        step(0, 1, 0, pk(7, 7, 7, 7, 7, 7, 7, 7));
        step(0, 1, 0, pk(255, 0, 255, 0, 128, 128, 1, 254));
        step(0, 1, 1, pk(255, 0, 255, 0, 128, 128, 1, 254));
        // Hold: accept once, then wiggle data and direction with ena low.
        step(0, 1, 0, pk(3, 1, 2, 0, 9, 9, 4, 5));
        for (int i = 0; i < 6; i++) step(0, 0, i[0], rnd_vec());
        // Streaming random with random direction.
        for (int i = 0; i < 1000; i++) step(0, 1, 1'($urandom_range(0, 1)), rnd_vec());
        // Mid-stream reset while ena is high.
        step(1, 1, 0, rnd_vec());
        for (int i = 0; i < 3; i++) step(0, 0, 1, rnd_vec());
        for (int i = 0; i < 20; i++) step(0, 1, 1'($urandom_range(0, 1)), rnd_vec());
        // Gapped stream: random ena.
        for (int i = 0; i < 60; i++) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_vec());
        for (int i = 0; i < 3; i++) step(0, 0, 0, rnd_vec());
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
